// File: rtl/adc_channel_scanner.sv
// adc_channel_scanner: round-robin ADC channel scanner with dummy-sample discard, 2^AVG_LOG2 averaging, result bank and frame pulse; define ADC_THRESH_EN for line_bits threshold logic
module adc_channel_scanner #(
  parameter int NUM_CH = 8,
  parameter int AVG_LOG2 = 2,
  parameter int TIMEOUT = 255
`ifdef ADC_THRESH_EN
  , parameter logic [11:0] THRESH_LVL = 12'd2048
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  output logic        spi_req,
  output logic [2:0]  spi_ch,
  input  logic        spi_done,
  input  logic [11:0] spi_data,
  input  logic [2:0]  rd_ch,
  output logic [11:0] rd_data,
  output logic        frame_done,
  output logic        timeout_err,
  output logic [7:0]  line_bits
);
  localparam int AW = 12 + AVG_LOG2;
  localparam int KW = AVG_LOG2 + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, REQ, WAIT, ACC, STORE, NEXT} state_t;
  state_t state, nxt;
  logic [2:0] chan;
  logic [AW-1:0] acc;
  logic [KW-1:0] kept;
  logic [TW-1:0] wcnt;
  logic [11:0] sample, avg, wr_val;
  logic [11:0] bank [8];
  logic first, last, tmo, wr_en;
  assign last = chan == 3'(NUM_CH - 1);
  assign tmo = state == WAIT && !spi_done && wcnt == TW'(TIMEOUT - 1);
  assign avg = 12'(acc >> AVG_LOG2);
  assign wr_en = state == STORE || tmo;
  assign wr_val = tmo ? 12'hFFF : avg;
  assign spi_req = state == REQ;
  assign spi_ch = chan;
  assign frame_done = state == NEXT && last;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE: nxt = enable ? REQ : IDLE;
      REQ: nxt = WAIT;
      WAIT: nxt = spi_done ? ACC : tmo ? NEXT : WAIT;
      ACC: nxt = (!first && kept == KW'(2 ** AVG_LOG2 - 1)) ? STORE : REQ;
      STORE: nxt = NEXT;
      NEXT: nxt = (last && !enable) ? IDLE : REQ;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      chan <= '0;
      acc <= '0;
      kept <= '0;
      first <= 1'b1;
      wcnt <= '0;
      sample <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state == REQ) wcnt <= '0;
      else if (state == WAIT) wcnt <= wcnt + 1'b1;
      if (state == WAIT && spi_done) sample <= spi_data;
      if (state == ACC && first) first <= 1'b0;
      if (state == ACC && !first) begin
        acc <= acc + AW'(sample);
        kept <= kept + 1'b1;
      end
      if (wr_en) begin
        acc <= '0;
        kept <= '0;
      end
      if (tmo) timeout_err <= 1'b1;
      if (state == NEXT) begin
        chan <= last ? 3'd0 : chan + 3'd1;
        first <= 1'b1;
      end
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < 8; i++) bank[i] <= '0;
      rd_data <= '0;
    end else begin
      rd_data <= bank[rd_ch];
      if (wr_en) bank[chan] <= wr_val;
    end
`ifdef ADC_THRESH_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) line_bits <= '0;
    else if (wr_en) line_bits[chan] <= wr_val >= THRESH_LVL;
`else
  assign line_bits = 8'h00;
`endif
endmodule

// File: tb/tb_adc_channel_scanner.sv
// tb_adc_channel_scanner: directed checks of two scanner configurations against hand-computed results
module tb_adc_channel_scanner;
  logic clk = 0, rst = 1;
  logic a_en = 0, a_req, a_done = 0, a_fd, a_te;
  logic [2:0] a_ch, a_rdch = 0, a_last = 3'd7;
  logic [11:0] a_data = 0, a_rd;
  logic [7:0] a_lb;
  int a_idx = 0;
  logic b_en = 0, b_req, b_done, b_dm = 0, b_dx = 0, b_fd, b_te, b_auto = 1, b_hold = 0;
  logic [2:0] b_ch, b_rdch = 0, b_cur = 0;
  logic [11:0] b_data = 0, b_rd;
  logic [7:0] b_lb;
  logic [11:0] b_val [8];
  int errors = 0, checks = 0;
  assign b_done = b_dm | b_dx;
  always #5 clk = ~clk;
  adc_channel_scanner #(.NUM_CH(2), .AVG_LOG2(2), .TIMEOUT(255)) dut_a (
    .clk(clk), .rst(rst), .enable(a_en), .spi_req(a_req), .spi_ch(a_ch), .spi_done(a_done),
    .spi_data(a_data), .rd_ch(a_rdch), .rd_data(a_rd), .frame_done(a_fd), .timeout_err(a_te),
    .line_bits(a_lb));
  adc_channel_scanner #(.NUM_CH(8), .AVG_LOG2(0), .TIMEOUT(20)) dut_b (
    .clk(clk), .rst(rst), .enable(b_en), .spi_req(b_req), .spi_ch(b_ch), .spi_done(b_done),
    .spi_data(b_data), .rd_ch(b_rdch), .rd_data(b_rd), .frame_done(b_fd), .timeout_err(b_te),
    .line_bits(b_lb));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic run(input bit sel, output int reqs, output bit ok);
    reqs = 0;
    ok = 0;
    if (sel) b_en = 1; else a_en = 1;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk);
      if (sel ? b_req : a_req) reqs++;
      if (sel ? b_fd : a_fd) begin
        ok = 1;
        if (sel) b_en = 0; else a_en = 0;
      end
    end
  endtask
  task automatic watch(input bit sel, input int n, output int reqs, output int fds);
    reqs = 0;
    fds = 0;
    repeat (n) begin
      @(negedge clk);
      if (sel ? b_req : a_req) reqs++;
      if (sel ? b_fd : a_fd) fds++;
    end
  endtask
  task automatic rd(input bit sel, input logic [2:0] c, output logic [11:0] v);
    a_rdch = c;
    b_rdch = c;
    @(negedge clk);
    v = sel ? b_rd : a_rd;
  endtask
  task automatic wait_req(input logic [2:0] c, input bit any, output bit ok);
    ok = 0;
    for (int i = 0; i < 1000 && !ok; i++) begin
      @(negedge clk);
      ok = b_req && (any || b_ch == c);
    end
  endtask
  initial forever begin
    @(negedge clk);
    if (a_req) begin
      a_idx = (a_ch == a_last) ? a_idx + 1 : 0;
      a_last = a_ch;
      repeat (2) @(negedge clk);
      a_data = (a_idx == 0) ? 12'd999 : 12'(a_idx * 100);
      a_done = 1;
      @(negedge clk);
      a_done = 0;
    end
  end
  initial forever begin
    @(negedge clk);
    if (b_req && b_auto) begin
      b_cur = b_ch;
      repeat (2) @(negedge clk);
      if (!(b_hold && b_cur == 3'd3)) begin
        b_data = b_val[b_cur];
        b_dm = 1;
        @(negedge clk);
        b_dm = 0;
      end
    end
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int n, f;
    bit ok;
    logic [11:0] v;
    for (int i = 0; i < 8; i++) b_val[i] = 12'hABC;
    cyc(3);
    chk("rst_b_req", b_req, 0);
    chk("rst_b_ch", b_ch, 0);
    chk("rst_b_rd", b_rd, 0);
    chk("rst_b_fd", b_fd, 0);
    chk("rst_b_te", b_te, 0);
    chk("rst_b_lb", b_lb, 0);
    chk("rst_a_req", a_req, 0);
    rst = 0;
    watch(1, 8, n, f);
    chk("idle_no_req", n, 0);
    run(0, n, ok);
    chk("t1_frame", ok, 1);
    chk("t1_reqs", n, 10);
    cyc(1);
    chk("t1_fd_pulse", a_fd, 0);
    rd(0, 3'd0, v);
    chk("t1_bank0", v, 250);
    rd(0, 3'd1, v);
    chk("t1_bank1", v, 250);
    rd(0, 3'd2, v);
    chk("t1_bank2_unused", v, 0);
    watch(0, 20, n, f);
    chk("t1_stopped", n, 0);
    run(1, n, ok);
    chk("t2_frame", ok, 1);
    chk("t2_reqs", n, 16);
    for (int i = 0; i < 8; i++) begin
      rd(1, 3'(i), v);
      chk($sformatf("t2_bank%0d", i), v, 12'hABC);
    end
    chk("t2_no_err", b_te, 0);
    for (int i = 0; i < 8; i++) b_val[i] = 12'h123;
    b_hold = 1;
    b_en = 1;
    wait_req(3'd3, 0, ok);
    chk("t3_reach_ch3", ok, 1);
    cyc(20);
    chk("t3_err_before", b_te, 0);
    cyc(1);
    chk("t3_err_set", b_te, 1);
    wait_req(3'd0, 1, ok);
    chk("t3_resume", ok, 1);
    chk("t3_next_ch", b_ch, 4);
    b_hold = 0;
    run(1, n, ok);
    chk("t3_frame", ok, 1);
    rd(1, 3'd3, v);
    chk("t3_bank3", v, 12'hFFF);
    rd(1, 3'd4, v);
    chk("t3_bank4", v, 12'h123);
    chk("t3_sticky", b_te, 1);
    for (int i = 0; i < 8; i++) b_val[i] = 12'h456;
    b_en = 1;
    wait_req(3'd2, 0, ok);
    chk("t4_reach_ch2", ok, 1);
    b_en = 0;
    watch(1, 400, n, f);
    chk("t4_reqs", n, 11);
    chk("t4_frames", f, 1);
    rd(1, 3'd2, v);
    chk("t4_bank2", v, 12'h456);
    rd(1, 3'd7, v);
    chk("t4_bank7", v, 12'h456);
    b_auto = 0;
    b_en = 1;
    wait_req(3'd0, 1, ok);
    chk("t5_req", ok, 1);
    cyc(1);
    rst = 1;
    #1;
    chk("t5_req_drop", b_req, 0);
    chk("t5_te_clr", b_te, 0);
    chk("t5_rd_clr", b_rd, 0);
    chk("t5_fd", b_fd, 0);
    b_en = 0;
    @(negedge clk);
    rst = 0;
    cyc(2);
    b_dx = 1;
    @(negedge clk);
    b_dx = 0;
    watch(1, 10, n, f);
    chk("t5_no_req", n, 0);
    rd(1, 3'd0, v);
    chk("t5_bank0", v, 0);
    rd(1, 3'd7, v);
    chk("t5_bank7", v, 0);
    for (int i = 0; i < 8; i++) b_val[i] = 12'd0;
    b_val[0] = 12'd2047;
    b_val[1] = 12'd2048;
    b_auto = 1;
    run(1, n, ok);
    chk("t6_frame", ok, 1);
    rd(1, 3'd1, v);
    chk("t6_bank1", v, 2048);
`ifdef ADC_THRESH_EN
    chk("t6_line_bits", b_lb, 8'b0000_0010);
`else
    chk("t6_line_bits", b_lb, 8'h00);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
